// File: rtl/i2c_target_responder.sv
// I2C target that answers an i2cmb master: filtered SCL/SDA front end, START/STOP
// detection, 7-bit address match, write receive with ACK/NACK, read via tx_req handshake.
module i2c_target_responder #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h22,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       addr_match_o,
    output logic       rnw_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_first_o,
    output logic       tx_req_o,
    input  logic [7:0] tx_data_i,
    input  logic       nack_next_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic [FILTER_LEN-2:0]  r_scl_hist, r_sda_hist;
    logic [FILTER_LEN-1:0]  w_scl_win, w_sda_win;
    logic r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;
    logic r_scl_rise, r_scl_fall, r_start, r_stop;

    logic [6:0] r_shift;
    logic [3:0] r_bitcnt;
    logic [7:0] r_tx_shift;
    logic       r_ack_phase, r_nack, r_first_pending;
    logic       r_sda_oe, r_rnw, r_addr_match, r_rx_valid, r_rx_first, r_tx_req;
    logic [7:0] r_rx_data;
    logic [7:0] w_byte;
    logic       w_addr_hit;

    // The synchronizer output counts as the newest of the FILTER_LEN samples.
    assign w_scl_win = {r_scl_hist, r_scl_sync[SYNC_STAGES-1]};
    assign w_sda_win = {r_sda_hist, r_sda_sync[SYNC_STAGES-1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_fd   <= 1'b1;
            r_sda_fd   <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_hist <= w_scl_win[FILTER_LEN-2:0];
            r_sda_hist <= w_sda_win[FILTER_LEN-2:0];
            if (&w_scl_win)       r_scl_f <= 1'b1;
            else if (~|w_scl_win) r_scl_f <= 1'b0;
            if (&w_sda_win)       r_sda_f <= 1'b1;
            else if (~|w_sda_win) r_sda_f <= 1'b0;
            r_scl_fd   <= r_scl_f;
            r_sda_fd   <= r_sda_f;
            r_scl_rise <= r_scl_f & ~r_scl_fd;
            r_scl_fall <= ~r_scl_f & r_scl_fd;
            r_start    <= r_scl_f & r_scl_fd & r_sda_fd & ~r_sda_f;
            r_stop     <= r_scl_f & r_scl_fd & ~r_sda_fd & r_sda_f;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_start) begin
            w_state_nxt = S_ADDR;
        end else if (r_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:     if (r_scl_rise && r_bitcnt == 4'd7)
                                w_state_nxt = w_addr_hit ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK: if (r_scl_fall && r_ack_phase)
                                w_state_nxt = r_rnw ? S_RD_DATA : S_WR_DATA;
                S_WR_DATA:  if (r_scl_rise && r_bitcnt == 4'd7) w_state_nxt = S_WR_ACK;
                S_WR_ACK:   if (r_scl_fall && r_ack_phase) w_state_nxt = S_WR_DATA;
                S_RD_DATA:  if (r_scl_fall && r_bitcnt == 4'd8) w_state_nxt = S_RD_ACK;
                S_RD_ACK:   if (r_scl_rise) w_state_nxt = r_sda_f ? S_IGNORE : S_RD_DATA;
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_byte       = {r_shift, r_sda_f};
        w_addr_hit   = (w_byte[7:1] == SLAVE_ADDR);
        // Mask the registered drive so an illegal START never fights our own SDA pull.
        sda_oe_o     = r_sda_oe & ~r_start & ~r_stop;
        start_o      = r_start;
        stop_o       = r_stop;
        addr_match_o = r_addr_match;
        rnw_o        = r_rnw;
        rx_data_o    = r_rx_data;
        rx_valid_o   = r_rx_valid;
        rx_first_o   = r_rx_first;
        tx_req_o     = r_tx_req;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shift         <= '0;
            r_bitcnt        <= '0;
            r_tx_shift      <= '0;
            r_ack_phase     <= 1'b0;
            r_nack          <= 1'b0;
            r_first_pending <= 1'b0;
            r_sda_oe        <= 1'b0;
            r_rnw           <= 1'b0;
            r_addr_match    <= 1'b0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_rx_first      <= 1'b0;
            r_tx_req        <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            r_tx_req   <= 1'b0;
            if (r_tx_req) r_tx_shift <= tx_data_i;
            if (r_start || r_stop) begin
                r_addr_match <= 1'b0;
                r_sda_oe     <= 1'b0;
                r_bitcnt     <= '0;
                r_ack_phase  <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: if (r_scl_rise) begin
                        r_shift <= w_byte[6:0];
                        if (r_bitcnt == 4'd7) begin
                            r_bitcnt <= '0;
                            if (w_addr_hit) begin
                                r_rnw           <= w_byte[0];
                                r_tx_req        <= w_byte[0];
                                r_first_pending <= 1'b1;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                    S_ADDR_ACK: if (r_scl_fall) begin
                        if (!r_ack_phase) begin
                            r_sda_oe     <= 1'b1;
                            r_addr_match <= 1'b1;
                            r_ack_phase  <= 1'b1;
                        end else begin
                            r_ack_phase <= 1'b0;
                            r_bitcnt    <= '0;
                            if (r_rnw) begin
                                r_sda_oe   <= ~r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            end else begin
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_WR_DATA: if (r_scl_rise) begin
                        r_shift <= w_byte[6:0];
                        if (r_bitcnt == 4'd7) begin
                            r_bitcnt        <= '0;
                            r_rx_data       <= w_byte;
                            r_rx_valid      <= 1'b1;
                            r_rx_first      <= r_first_pending;
                            r_first_pending <= 1'b0;
                            r_nack          <= nack_next_i;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end
                    S_WR_ACK: if (r_scl_fall) begin
                        r_sda_oe    <= ~r_ack_phase & ~r_nack;
                        r_ack_phase <= ~r_ack_phase;
                    end
                    S_RD_DATA: begin
                        if (r_scl_rise) r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_sda_oe   <= ~r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                    S_RD_ACK: if (r_scl_rise) begin
                        r_bitcnt <= '0;
                        if (!r_sda_f) r_tx_req <= 1'b1;
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench: a behavioural I2C master drives the open-drain bus and checks
// the target's ACKs, read data and handshake pulses against hand-computed values.
module tb_i2c_target_responder;

    localparam int unsigned Q = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       w_sda;
    logic       sda_oe, start_p, stop_p, addr_match, rnw, rx_valid, rx_first, tx_req;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    logic       nack_next = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int n_start = 0, n_stop = 0, n_txreq = 0, n_oe = 0, n_am = 0, n_rx = 0;
    logic [7:0] rx_dat [0:15];
    logic       rx_fst [0:15];

    assign w_sda = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_responder #(.SLAVE_ADDR(7'h22), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
        .clk_i(clk), .rst_i(rst), .scl_i(m_scl), .sda_i(w_sda), .sda_oe_o(sda_oe),
        .start_o(start_p), .stop_o(stop_p), .addr_match_o(addr_match), .rnw_o(rnw),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_first_o(rx_first),
        .tx_req_o(tx_req), .tx_data_i(tx_data), .nack_next_i(nack_next)
    );

    always @(negedge clk) begin
        if (start_p) n_start++;
        if (stop_p) n_stop++;
        if (tx_req) n_txreq++;
        if (sda_oe) n_oe++;
        if (addr_match) n_am++;
        if (rx_valid) begin
            if (n_rx < 16) begin
                rx_dat[n_rx] = rx_data;
                rx_fst[n_rx] = rx_first;
            end
            n_rx++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda = b;
        wait_q();
        m_scl = 1'b1;
        repeat (Q / 2) @(negedge clk);
        s = w_sda;
        repeat (Q / 2) @(negedge clk);
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        m_sda = 1'b1;
        wait_q();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(nack, s);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        logic       s;
        int b_start, b_stop, b_tx, b_oe, b_am, b_rx;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {sda_oe, start_p, stop_p, addr_match, rnw, rx_data, rx_valid, rx_first, tx_req}, 0);

        // Write 0x44: A5, 3C
        b_start = n_start; b_stop = n_stop; b_rx = n_rx;
        i2c_start();
        wr_byte(8'h44, ack); check("t1_addr_ack", ack, 1);
        check("t1_addr_match", addr_match, 1);
        check("t1_rnw", rnw, 0);
        wr_byte(8'hA5, ack); check("t1_d0_ack", ack, 1);
        wr_byte(8'h3C, ack); check("t1_d1_ack", ack, 1);
        i2c_stop();
        check("t1_rx_count", n_rx - b_rx, 2);
        check("t1_rx0_data", rx_dat[b_rx], 8'hA5);
        check("t1_rx0_first", rx_fst[b_rx], 1);
        check("t1_rx1_data", rx_dat[b_rx+1], 8'h3C);
        check("t1_rx1_first", rx_fst[b_rx+1], 0);
        check("t1_starts", n_start - b_start, 1);
        check("t1_stops", n_stop - b_stop, 1);
        check("t1_match_clr", addr_match, 0);

        // Foreign address 0x23
        b_start = n_start; b_stop = n_stop; b_rx = n_rx; b_oe = n_oe; b_am = n_am;
        i2c_start();
        wr_byte(8'h46, ack); check("t2_addr_nack", ack, 0);
        wr_byte(8'h12, ack); check("t2_data_nack", ack, 0);
        i2c_stop();
        check("t2_oe_cycles", n_oe - b_oe, 0);
        check("t2_am_cycles", n_am - b_am, 0);
        check("t2_rx_count", n_rx - b_rx, 0);
        check("t2_starts", n_start - b_start, 1);
        check("t2_stops", n_stop - b_stop, 1);

        // Read 0x45: 96 (ACK), 0F (NACK)
        b_tx = n_txreq; b_stop = n_stop;
        tx_data = 8'h96;
        i2c_start();
        wr_byte(8'h45, ack); check("t3_addr_ack", ack, 1);
        check("t3_rnw", rnw, 1);
        tx_data = 8'h0F;
        rd_byte(1'b0, rb); check("t3_rd0", rb, 8'h96);
        rd_byte(1'b1, rb); check("t3_rd1", rb, 8'h0F);
        check("t3_txreq", n_txreq - b_tx, 2);
        b_oe = n_oe;
        rd_byte(1'b1, rb); check("t3_after_nack_bus", rb, 8'hFF);
        check("t3_after_nack_oe", n_oe - b_oe, 0);
        check("t3_no_more_req", n_txreq - b_tx, 2);
        i2c_stop();
        check("t3_stops", n_stop - b_stop, 1);

        // Write 0x10, repeated START, read C3
        b_start = n_start; b_rx = n_rx;
        tx_data = 8'hC3;
        i2c_start();
        wr_byte(8'h44, ack); check("t4_waddr_ack", ack, 1);
        wr_byte(8'h10, ack); check("t4_wdata_ack", ack, 1);
        check("t4_rnw0", rnw, 0);
        i2c_start();
        wr_byte(8'h45, ack); check("t4_raddr_ack", ack, 1);
        check("t4_rnw1", rnw, 1);
        rd_byte(1'b1, rb); check("t4_rd", rb, 8'hC3);
        i2c_stop();
        check("t4_starts", n_start - b_start, 2);
        check("t4_rx_count", n_rx - b_rx, 1);
        check("t4_rx_data", rx_dat[b_rx], 8'h10);
        check("t4_rx_first", rx_fst[b_rx], 1);

        // nack_next_i on byte 0x55
        b_rx = n_rx;
        i2c_start();
        wr_byte(8'h44, ack); check("t5_addr_ack", ack, 1);
        nack_next = 1'b1;
        wr_byte(8'h55, ack); check("t5_nacked", ack, 0);
        nack_next = 1'b0;
        wr_byte(8'h66, ack); check("t5_acked", ack, 1);
        i2c_stop();
        check("t5_rx_count", n_rx - b_rx, 2);
        check("t5_rx0_data", rx_dat[b_rx], 8'h55);
        check("t5_rx0_first", rx_fst[b_rx], 1);
        check("t5_rx1_data", rx_dat[b_rx+1], 8'h66);
        check("t5_rx1_first", rx_fst[b_rx+1], 0);

        // One-cycle SDA glitch with SCL high
        b_start = n_start;
        wait_q();
        m_sda = 1'b0;
        @(negedge clk);
        m_sda = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_glitch_start", n_start - b_start, 0);

        // Reset inside the address ACK slot
        i2c_start();
        for (int i = 7; i >= 0; i--) clk_bit(((8'h44 >> i) & 8'h01) != 0, s);
        m_sda = 1'b1;
        for (int i = 0; i < 100 && !sda_oe; i++) @(negedge clk);
        check("t6_ack_driven", sda_oe, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_release", sda_oe, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        m_scl = 1'b0;
        wait_q();
        b_rx = n_rx; b_oe = n_oe;
        wr_byte(8'h77, ack); check("t6_post_rst_ack", ack, 0);
        check("t6_post_rst_oe", n_oe - b_oe, 0);
        check("t6_post_rst_rx", n_rx - b_rx, 0);
        i2c_start();
        wr_byte(8'h44, ack); check("t6_resume_ack", ack, 1);
        i2c_stop();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
